pixel_sensor_ctrl: RTL and testbench
====================================

// Module: pixel_sensor_ctrl
// PURPOSE
//  Frame sequencer for the PIXEL_ARRAY macro. Runs IDLE->ERASE->EXPOSE->CONVERT->READ per frame.
//  Drives the phase strobes, the 8-bit ADC ramp counter and the one-hot row select.
//  Captures each row's DATA_OUT and streams it out over a valid/ready interface.
// PARAMETERS
//  PIXEL_ARRAY_WIDTH   2    columns per row; one 8-bit value per column
//  PIXEL_ARRAY_HEIGHT  2    rows; width of the one-hot read bus
//  C_ERASE             5    erase strobe length in cycles, >=1
//  C_EXPOSE            255  expose strobe length in cycles, >=1
//  C_CONVERT           255  convert length in cycles, 1..256
//  C_READ_ROW          5    cycles each row is selected before capture, >=1
// PORTS
//  clk            in   1        single clock; all logic on posedge
//  reset          in   1        synchronous, active-high
//  start          in   1        begin one frame; sampled only in IDLE
//  erase          out  1        PIXEL_ARRAY ERASE
//  expose         out  1        PIXEL_ARRAY EXPOSE; also gates the analog bias
//  convert        out  1        ramp enable; gates the analog ramp
//  pixel_counter  out  8        PIXEL_ARRAY COUNTER (digital ramp)
//  read           out  H        one-hot row select to PIXEL_ARRAY READ
//  row_data       in   W*8      PIXEL_ARRAY DATA_OUT
//  out_data       out  W*8      captured row
//  out_row        out  RW       row index of out_data; RW = max(1,$clog2(H))
//  out_valid      out  1        out_data and out_row are valid
//  out_ready      in   1        consumer accepts when out_valid & out_ready
//  busy           out  1        high in every state except IDLE
//  frame_done     out  1        one-cycle pulse after the last row is captured
// BEHAVIOUR
//  - Reset (any state, mid-frame included): next edge sets state=IDLE and drives every output to 0.
//    Any in-flight row is discarded.
//  - Strobes are Moore-decoded from the registered state.
//    erase is high exactly while in ERASE; likewise expose, convert and read.
//  - Between phases there is exactly one GAP cycle with all strobes low (break-before-make).
//  - IDLE, start=1: the next cycle is the first of C_ERASE ERASE cycles. start is ignored while busy.
//  - EXPOSE: C_EXPOSE cycles. CONVERT: C_CONVERT cycles.
//  - pixel_counter = 0 on the first CONVERT cycle, then +1 per cycle; saturates at 255, no wrap.
//    pixel_counter = 0 in every other state.
//  - READ: rows r = 0..H-1 in order. read = 1<<r for C_READ_ROW cycles; no gap between rows.
//    On the last cycle of row r, row_data is registered into out_data/out_row.
//    out_valid is set on the following cycle.
//  - Handshake: out_data and out_row are held stable while out_valid & !out_ready.
//    out_valid clears after acceptance unless a new capture occurs on the same edge.
//  - Backpressure: if the last cycle of a row is reached while out_valid & !out_ready,
//    the controller holds read on that row and the row timer frozen, then captures on the edge
//    where out_ready=1.
//  - After capture of row H-1: GAP, then IDLE, with frame_done=1 in the GAP cycle.
//    The final beat may still be pending when IDLE is entered; a new start is still accepted.
//  - Unbackpressured frame, start edge to frame_done:
//    C_ERASE + C_EXPOSE + C_CONVERT + H*C_READ_ROW + 4 cycles.
// CONFIGURATION
//  PIXEL_CTRL_CONTINUOUS_EN
//   - defined: after the READ GAP, state goes straight to ERASE with no start needed.
//     frame_done still pulses; busy stays high; start is ignored.
//   - undefined: return to IDLE and wait for start.
// STRUCTURE
//  - pixel_ctrl_pkg holds:
//    - typedef enum logic [2:0] {IDLE, ERASE, EXPOSE, CONVERT, READ, GAP} ctrl_state_t
//    - default C_* durations
//    - localparam PIX_BITS = 8
//  - Sub-module phase_timer: loadable 9-bit down-counter with load, hold and done.
//    One instance times every phase, including per-row timing.
//  - Top level contains the FSM, row one-hot shifter, ramp counter and output register.
// TESTING  (defaults, W=2, H=2, out_ready=1 unless stated)
//  1. start pulse in IDLE -> erase high 5 cycles, 1-cycle gap, expose high 255, gap,
//     convert 255 with pixel_counter 0..254, frame_done 529 cycles after start.
//  2. READ phase -> read=2'b01 for 5 cycles, then 2'b10 for 5 cycles.
//     Two beats: out_row=0, then out_row=1, each out_data == row_data sampled at row end.
//  3. out_ready=0 during READ -> read stuck at 2'b10 after row 0 is captured;
//     out_data is stable. Raising out_ready -> row 1 captured on that edge, frame completes.
//  4. C_CONVERT=256 -> pixel_counter reaches 255 and holds 1 cycle; never reads 0 mid-convert.
//  5. reset at EXPOSE cycle 100 -> next cycle all outputs 0, busy=0.
//     start then yields a full 5-cycle erase.
//  6. PIXEL_CTRL_CONTINUOUS_EN defined, one start -> three back-to-back frames,
//     3 frame_done pulses, busy never low.

Source files
------------

// File: rtl/pixel_ctrl_pkg.sv
// Shared types, default phase durations and helpers for the pixel sensor frame sequencer.
package pixel_ctrl_pkg;

    localparam int PIX_BITS   = 8;
    localparam int TIMER_BITS = 9;

    localparam int C_ERASE_DEF    = 5;
    localparam int C_EXPOSE_DEF   = 255;
    localparam int C_CONVERT_DEF  = 255;
    localparam int C_READ_ROW_DEF = 5;

    typedef enum logic [2:0] {IDLE, ERASE, EXPOSE, CONVERT, READ, GAP} ctrl_state_t;

    // Digital ramp stops at full scale rather than wrapping back to zero.
    function automatic logic [PIX_BITS-1:0] ramp_next(input logic [PIX_BITS-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    function automatic int row_bits(input int h);
        return (h > 1) ? $clog2(h) : 1;
    endfunction

endpackage

// File: rtl/pixel_sensor_ctrl_if.sv
// Captured-row stream (valid/ready) between the frame sequencer and its consumer.
interface pixel_sensor_ctrl_if #(
    parameter int PIXEL_ARRAY_WIDTH  = 2,
    parameter int PIXEL_ARRAY_HEIGHT = 2
);
    import pixel_ctrl_pkg::*;

    localparam int RW = row_bits(PIXEL_ARRAY_HEIGHT);

    logic [PIXEL_ARRAY_WIDTH*PIX_BITS-1:0] out_data;
    logic [RW-1:0]                         out_row;
    logic                                  out_valid;
    logic                                  out_ready;

    modport master (output out_data, output out_row, output out_valid, input out_ready);
    modport slave  (input out_data, input out_row, input out_valid, output out_ready);

endinterface

// File: rtl/pixel_sensor_ctrl_phase_timer.sv
// Loadable 9-bit down-counter shared by every phase; done_o marks the last cycle of a phase.
module phase_timer
    import pixel_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_i,
    input  logic [TIMER_BITS-1:0] load_val_i,
    input  logic                  hold_i,
    output logic                  done_o
);

    logic [TIMER_BITS-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (!hold_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/pixel_sensor_ctrl.sv
// Frame sequencer for PIXEL_ARRAY: ERASE, EXPOSE, CONVERT, READ separated by one-cycle GAPs.
// Define PIXEL_CTRL_CONTINUOUS_EN to free-run frames back to back after the first start.
module pixel_sensor_ctrl
    import pixel_ctrl_pkg::*;
#(
    parameter int PIXEL_ARRAY_WIDTH  = 2,
    parameter int PIXEL_ARRAY_HEIGHT = 2,
    parameter int C_ERASE            = C_ERASE_DEF,
    parameter int C_EXPOSE           = C_EXPOSE_DEF,
    parameter int C_CONVERT          = C_CONVERT_DEF,
    parameter int C_READ_ROW         = C_READ_ROW_DEF
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    output logic                                  erase,
    output logic                                  expose,
    output logic                                  convert,
    output logic [PIX_BITS-1:0]                   pixel_counter,
    output logic [PIXEL_ARRAY_HEIGHT-1:0]         read,
    input  logic [PIXEL_ARRAY_WIDTH*PIX_BITS-1:0] row_data,
    output logic                                  busy,
    output logic                                  frame_done,
    pixel_sensor_ctrl_if.master                   out_if
);

    localparam int RW = row_bits(PIXEL_ARRAY_HEIGHT);
    localparam logic [TIMER_BITS-1:0] LD_ERASE   = TIMER_BITS'(C_ERASE - 1);
    localparam logic [TIMER_BITS-1:0] LD_EXPOSE  = TIMER_BITS'(C_EXPOSE - 1);
    localparam logic [TIMER_BITS-1:0] LD_CONVERT = TIMER_BITS'(C_CONVERT - 1);
    localparam logic [TIMER_BITS-1:0] LD_ROW     = TIMER_BITS'(C_READ_ROW - 1);
    localparam logic [RW-1:0]         LAST_ROW   = RW'(PIXEL_ARRAY_HEIGHT - 1);

    ctrl_state_t state_q, state_d;
    ctrl_state_t prev_q, prev_d;

    logic [RW-1:0]                         row_q, row_d;
    logic [PIXEL_ARRAY_HEIGHT-1:0]         sel_q, sel_d;
    logic [PIX_BITS-1:0]                   pc_q, pc_d;
    logic [PIXEL_ARRAY_WIDTH*PIX_BITS-1:0] odata_q, odata_d;
    logic [RW-1:0]                         orow_q, orow_d;
    logic                                  ovalid_q, ovalid_d;

    logic                  t_load, t_hold, t_done;
    logic [TIMER_BITS-1:0] t_val;

    phase_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (t_load),
        .load_val_i (t_val),
        .hold_i     (t_hold),
        .done_o     (t_done)
    );

    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        t_load   = 1'b0;
        t_val    = '0;
        t_hold   = 1'b0;
        row_d    = row_q;
        sel_d    = sel_q;
        odata_d  = odata_q;
        orow_d   = orow_q;
        ovalid_d = ovalid_q & ~out_if.out_ready;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ERASE;
                    t_load  = 1'b1;
                    t_val   = LD_ERASE;
                end
            end
            ERASE, EXPOSE, CONVERT: begin
                if (t_done) begin
                    state_d = GAP;
                    prev_d  = state_q;
                end
            end
            GAP: begin
                case (prev_q)
                    ERASE: begin
                        state_d = EXPOSE;
                        t_load  = 1'b1;
                        t_val   = LD_EXPOSE;
                    end
                    EXPOSE: begin
                        state_d = CONVERT;
                        t_load  = 1'b1;
                        t_val   = LD_CONVERT;
                    end
                    CONVERT: begin
                        state_d = READ;
                        t_load  = 1'b1;
                        t_val   = LD_ROW;
                    end
`ifdef PIXEL_CTRL_CONTINUOUS_EN
                    READ: begin
                        state_d = ERASE;
                        t_load  = 1'b1;
                        t_val   = LD_ERASE;
                    end
`else
                    READ:    state_d = IDLE;
`endif
                    default: state_d = IDLE;
                endcase
            end
            READ: begin
                if (t_done) begin
                    // A pending beat blocks the capture; the row stays selected until it drains.
                    if (ovalid_q && !out_if.out_ready) begin
                        t_hold = 1'b1;
                    end else begin
                        odata_d  = row_data;
                        orow_d   = row_q;
                        ovalid_d = 1'b1;
                        if (row_q == LAST_ROW) begin
                            state_d = GAP;
                            prev_d  = READ;
                        end else begin
                            row_d  = row_q + 1'b1;
                            sel_d  = sel_q << 1;
                            t_load = 1'b1;
                            t_val  = LD_ROW;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != READ) begin
            row_d = '0;
            sel_d = PIXEL_ARRAY_HEIGHT'(1);
        end

        pc_d = '0;
        if (state_d == CONVERT && state_q == CONVERT) begin
            pc_d = ramp_next(pc_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            prev_q   <= IDLE;
            row_q    <= '0;
            sel_q    <= PIXEL_ARRAY_HEIGHT'(1);
            pc_q     <= '0;
            odata_q  <= '0;
            orow_q   <= '0;
            ovalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            row_q    <= row_d;
            sel_q    <= sel_d;
            pc_q     <= pc_d;
            odata_q  <= odata_d;
            orow_q   <= orow_d;
            ovalid_q <= ovalid_d;
        end
    end

    assign erase         = (state_q == ERASE);
    assign expose        = (state_q == EXPOSE);
    assign convert       = (state_q == CONVERT);
    assign read          = (state_q == READ) ? sel_q : '0;
    assign pixel_counter = pc_q;
    assign busy          = (state_q != IDLE);
    assign frame_done    = (state_q == GAP) && (prev_q == READ);

    assign out_if.out_data  = odata_q;
    assign out_if.out_row   = orow_q;
    assign out_if.out_valid = ovalid_q;

endmodule

// File: tb/tb_pixel_sensor_ctrl.sv
// Directed bench for pixel_sensor_ctrl: frame timing, row capture, backpressure, reset, ramp saturation.
module tb_pixel_sensor_ctrl;
    import pixel_ctrl_pkg::*;

    localparam int W = 2;
    localparam int H = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic        erase, expose, convert, busy, fdone;
    logic [7:0]  pc;
    logic [1:0]  rd;
    logic [15:0] row_data = 16'h0;
    logic        erase2, expose2, conv2, busy2, fd2;
    logic [7:0]  pc2;
    logic [1:0]  rd2;
    logic [15:0] row_data2 = 16'hBEEF;

    pixel_sensor_ctrl_if #(.PIXEL_ARRAY_WIDTH(W), .PIXEL_ARRAY_HEIGHT(H)) bus ();
    pixel_sensor_ctrl_if #(.PIXEL_ARRAY_WIDTH(W), .PIXEL_ARRAY_HEIGHT(H)) bus2 ();

    pixel_sensor_ctrl #(.PIXEL_ARRAY_WIDTH(W), .PIXEL_ARRAY_HEIGHT(H)) dut (
        .clk(clk), .reset(reset), .start(start), .erase(erase), .expose(expose),
        .convert(convert), .pixel_counter(pc), .read(rd), .row_data(row_data),
        .busy(busy), .frame_done(fdone), .out_if(bus)
    );

    pixel_sensor_ctrl #(.PIXEL_ARRAY_WIDTH(W), .PIXEL_ARRAY_HEIGHT(H), .C_ERASE(2),
                        .C_EXPOSE(3), .C_CONVERT(256), .C_READ_ROW(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .erase(erase2), .expose(expose2),
        .convert(conv2), .pixel_counter(pc2), .read(rd2), .row_data(row_data2),
        .busy(busy2), .frame_done(fd2), .out_if(bus2)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, cyc = 0;
    int f_er, f_ex, f_cv, f_rd0, f_rd1, f_fd, l_fd;
    int n_er, n_ex, n_cv, n_r0, n_r1, n_fd;
    int overlap, nogap, pc_bad, pc_last, prev_pc, busy_low, beats;
    logic       prev_conv;
    logic [3:0] s_prev;
    logic [15:0] b_data [4];
    logic [0:0]  b_row [4];

    function automatic logic [15:0] rowval(input int c);
        return 16'((c * 263) ^ 16'hC3A5);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        row_data = rowval(cyc);
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; start2 = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic kick();
        cyc = 0;
        row_data = rowval(0);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clr_stats();
        f_er = 0; f_ex = 0; f_cv = 0; f_rd0 = 0; f_rd1 = 0; f_fd = 0; l_fd = 0;
        n_er = 0; n_ex = 0; n_cv = 0; n_r0 = 0; n_r1 = 0; n_fd = 0;
        overlap = 0; nogap = 0; pc_bad = 0; pc_last = -1; prev_pc = 0; busy_low = 0; beats = 0;
        prev_conv = 1'b0; s_prev = 4'b0;
    endtask

    task automatic observe();
        logic [3:0] s;
        int exp_pc;
        s = {erase, expose, convert, (rd != 2'b00)};
        if (erase)  begin n_er++; if (f_er == 0) f_er = cyc; end
        if (expose) begin n_ex++; if (f_ex == 0) f_ex = cyc; end
        if (convert) begin n_cv++; if (f_cv == 0) f_cv = cyc; end
        if (rd == 2'b01) begin n_r0++; if (f_rd0 == 0) f_rd0 = cyc; end
        if (rd == 2'b10) begin n_r1++; if (f_rd1 == 0) f_rd1 = cyc; end
        if (fdone) begin n_fd++; l_fd = cyc; if (f_fd == 0) f_fd = cyc; end
        if ((32'(s[0]) + 32'(s[1]) + 32'(s[2]) + 32'(s[3])) > 1) overlap++;
        if (s != 4'b0 && s_prev != 4'b0 && s != s_prev) nogap++;
        if (!busy) busy_low++;
        if (convert) begin
            exp_pc = !prev_conv ? 0 : ((prev_pc == 255) ? 255 : prev_pc + 1);
            if (int'(pc) != exp_pc) pc_bad++;
            pc_last = int'(pc);
        end else if (pc != 8'd0) begin
            pc_bad++;
        end
        prev_conv = convert;
        prev_pc = int'(pc);
        s_prev = s;
        if (bus.out_valid && bus.out_ready && beats < 4) begin
            b_data[beats] = bus.out_data;
            b_row[beats] = bus.out_row;
            beats++;
        end
    endtask

    initial begin
        int n_cv2, n255, zero_mid, pc2_last, n_er2, n_ex2, n_rd2, n_fd2, f_fd2, n_v2;

        bus.out_ready = 1'b1;
        bus2.out_ready = 1'b1;

        // Reset state
        do_reset();
        chk("rst_erase", erase, 0);
        chk("rst_expose", expose, 0);
        chk("rst_convert", convert, 0);
        chk("rst_pc", pc, 0);
        chk("rst_read", rd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fdone", fdone, 0);
        chk("rst_valid", bus.out_valid, 0);

        // Full unbackpressured frame: phase timing, ramp, two beats
        kick();
        clr_stats();
        while (cyc <= 529) begin observe(); tick(); end
        chk("erase_first", f_er, 1);
        chk("erase_len", n_er, 5);
        chk("expose_first", f_ex, 7);
        chk("expose_len", n_ex, 255);
        chk("convert_first", f_cv, 263);
        chk("convert_len", n_cv, 255);
        chk("pc_last", pc_last, 254);
        chk("pc_bad", pc_bad, 0);
        chk("read0_first", f_rd0, 519);
        chk("read0_len", n_r0, 5);
        chk("read1_first", f_rd1, 524);
        chk("read1_len", n_r1, 5);
        chk("fdone_cycle", f_fd, 529);
        chk("fdone_count", n_fd, 1);
        chk("overlap", overlap, 0);
        chk("nogap", nogap, 0);
        chk("busy_low", busy_low, 0);
        chk("beats", beats, 2);
        chk("beat0_row", b_row[0], 0);
        chk("beat0_data", b_data[0], rowval(523));
        chk("beat1_row", b_row[1], 1);
        chk("beat1_data", b_data[1], rowval(528));
`ifndef PIXEL_CTRL_CONTINUOUS_EN
        chk("idle_busy", busy, 0);
        chk("idle_fdone", fdone, 0);
`endif

        // Backpressure: row 1 stalls until out_ready rises
        do_reset();
        bus.out_ready = 1'b0;
        kick();
        clr_stats();
        while (cyc < 540) begin observe(); tick(); end
        chk("bp_read1_first", f_rd1, 524);
        chk("bp_read1_len", n_r1, 16);
        chk("bp_read_hold", rd, 2'b10);
        chk("bp_valid", bus.out_valid, 1);
        chk("bp_row", bus.out_row, 0);
        chk("bp_data_stable", bus.out_data, rowval(523));
        chk("bp_no_fdone", n_fd, 0);
        bus.out_ready = 1'b1;
        tick();
        chk("bp_cap_row", bus.out_row, 1);
        chk("bp_cap_data", bus.out_data, rowval(540));
        chk("bp_cap_valid", bus.out_valid, 1);
        chk("bp_fdone", fdone, 1);
        chk("bp_read_off", rd, 0);
        tick();
        chk("bp_drained", bus.out_valid, 0);
`ifndef PIXEL_CTRL_CONTINUOUS_EN
        chk("bp_idle", busy, 0);
`endif

        // Reset at EXPOSE cycle 100 with a stale capture still held
        if (busy) do_reset();
        kick();
        while (cyc < 106) tick();
        chk("pre_rst_expose", expose, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_expose", expose, 0);
        chk("mid_rst_erase", erase, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_data", bus.out_data, 0);
        chk("mid_rst_row", bus.out_row, 0);
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_pc", pc, 0);
        chk("mid_rst_read", rd, 0);
        tick();
        chk("post_rst_idle", busy, 0);
        kick();
        clr_stats();
        while (cyc <= 7) begin observe(); tick(); end
        chk("restart_erase_first", f_er, 1);
        chk("restart_erase_len", n_er, 5);
        chk("restart_expose_first", f_ex, 7);

`ifdef PIXEL_CTRL_CONTINUOUS_EN
        // Continuous mode: one start, three back-to-back frames
        do_reset();
        kick();
        clr_stats();
        while (cyc <= 1587) begin observe(); tick(); end
        chk("cont_fdone_count", n_fd, 3);
        chk("cont_fdone_first", f_fd, 529);
        chk("cont_fdone_last", l_fd, 1587);
        chk("cont_busy_low", busy_low, 0);
        chk("cont_erase_len", n_er, 15);
        chk("cont_beats_cap", beats, 4);
`endif

        // 256-cycle convert: ramp saturates at 255 for exactly one cycle
        do_reset();
        cyc = 0;
        n_cv2 = 0; n255 = 0; zero_mid = 0; pc2_last = -1;
        n_er2 = 0; n_ex2 = 0; n_rd2 = 0; n_fd2 = 0; f_fd2 = 0; n_v2 = 0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        while (cyc <= 300) begin
            if (conv2) begin
                n_cv2++;
                if (pc2 == 8'd255) n255++;
                if (pc2 == 8'd0 && n_cv2 > 1) zero_mid++;
                pc2_last = int'(pc2);
            end
            if (erase2) n_er2++;
            if (expose2) n_ex2++;
            if (rd2 != 2'b00) n_rd2++;
            if (fd2) begin n_fd2++; if (f_fd2 == 0) f_fd2 = cyc; end
            if (bus2.out_valid) n_v2++;
            tick();
        end
        chk("c256_len", n_cv2, 256);
        chk("c256_last", pc2_last, 255);
        chk("c256_sat_cycles", n255, 1);
        chk("c256_zero_mid", zero_mid, 0);
        chk("c256_erase_len", n_er2, 2);
        chk("c256_expose_len", n_ex2, 3);
        chk("c256_read_len", n_rd2, 4);
        chk("c256_fdone_cycle", f_fd2, 269);
        chk("c256_fdone_count", n_fd2, 1);
        chk("c256_beats", n_v2, 2);
        chk("c256_idle", busy2, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
